serial_pattern_source: RTL and testbench

SERIAL_PATTERN_SOURCE -- requirements
Module: serial_pattern_source

---
 rtl/serial_pattern_source.sv | 82 ++++++++
 tb/tb_serial_pattern_source.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_source.sv
// serial_pattern_source: LFSR-paced injector that serialises {start, dest, src, seq} frames MSB first.
module serial_pattern_source #(
    parameter int NODE_ID = 0,
    parameter int NUM_NODES = 9,
    parameter int ADDR_SZ = 4,
    parameter int PAYLOAD_SZ = 8,
    parameter int PIR = 255,
    parameter int MODE = 0,
    parameter int FIXED_DEST = 0,
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        busy,
    input  logic        send,
    output logic        data,
    output logic        active,
    output logic [15:0] packets_sent
);
    localparam int FRAME_LEN = 1 + 2 * ADDR_SZ + PAYLOAD_SZ;
    localparam int CW = $clog2(FRAME_LEN);
    localparam logic [ADDR_SZ-1:0] SRC = ADDR_SZ'(NODE_ID);
    localparam logic [ADDR_SZ-1:0] NEXT = ADDR_SZ'((NODE_ID + 1) % NUM_NODES);
    localparam logic [ADDR_SZ-1:0] MIRROR = ADDR_SZ'(NUM_NODES - 1 - NODE_ID);
    localparam logic [ADDR_SZ-1:0] FIXED = ADDR_SZ'(FIXED_DEST);
    localparam logic [7:0] RATE = 8'(PIR);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [7:0]             lfsr;
    logic [FRAME_LEN-2:0]   sr;
    logic [CW-1:0]          cnt;
    logic [ADDR_SZ-1:0]     rnd;
    logic [ADDR_SZ-1:0]     dest;
    logic [PAYLOAD_SZ-1:0]  seq;
    logic                   inject;

    assign rnd = ADDR_SZ'(32'(lfsr) % NUM_NODES);
    assign seq = PAYLOAD_SZ'(packets_sent);
    assign inject = send && (PIR == 255 || lfsr < RATE);

    // a random pick that lands on ourselves is redirected to the next node
    always_comb begin
        dest = MODE == 1 ? FIXED : MODE == 2 ? MIRROR : MODE == 3 ? NEXT : (rnd == SRC ? NEXT : rnd);
    end

    // sr holds the bits still to be sent after the one currently on data
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            lfsr <= SEED;
            sr <= '0;
            cnt <= '0;
            data <= 1'b0;
            active <= 1'b0;
            packets_sent <= '0;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state == IDLE) begin
                if (inject) begin
                    state <= SHIFT;
                    sr <= {dest, SRC, seq};
                    cnt <= CW'(FRAME_LEN - 1);
                    data <= 1'b1;
                    active <= 1'b1;
                end
            end else if (!busy) begin
                if (cnt == '0) begin
                    state <= IDLE;
                    data <= 1'b0;
                    active <= 1'b0;
                    packets_sent <= packets_sent + 16'd1;
                end else begin
                    data <= sr[FRAME_LEN-2];
                    sr <= {sr[FRAME_LEN-3:0], 1'b0};
                    cnt <= cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_pattern_source.sv
// tb_serial_pattern_source: four parameterisations checked every cycle against a frame-as-array model.
module tb_serial_pattern_source;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        busy_a = 1'b0, send_a = 1'b0;
    logic [3:1]  busy_r = '0, send_r = '0;
    logic [3:0]  busy_all, send_all;
    logic [3:0]  data_v, active_v;
    logic [15:0] ps_v [4];

    assign busy_all = {busy_r, busy_a};
    assign send_all = {send_r, send_a};

    serial_pattern_source #(.NODE_ID(2), .MODE(1), .FIXED_DEST(5), .PIR(255)) u_a (
        .clk(clk), .reset(reset), .busy(busy_a), .send(send_a),
        .data(data_v[0]), .active(active_v[0]), .packets_sent(ps_v[0]));
    serial_pattern_source #(.NODE_ID(3), .MODE(0), .PIR(200)) u_b (
        .clk(clk), .reset(reset), .busy(busy_r[1]), .send(send_r[1]),
        .data(data_v[1]), .active(active_v[1]), .packets_sent(ps_v[1]));
    serial_pattern_source #(.NODE_ID(2), .MODE(1), .FIXED_DEST(0), .PIR(0)) u_c (
        .clk(clk), .reset(reset), .busy(busy_r[2]), .send(send_r[2]),
        .data(data_v[2]), .active(active_v[2]), .packets_sent(ps_v[2]));
    serial_pattern_source #(.NODE_ID(3), .MODE(2), .PIR(255)) u_d (
        .clk(clk), .reset(reset), .busy(busy_r[3]), .send(send_r[3]),
        .data(data_v[3]), .active(active_v[3]), .packets_sent(ps_v[3]));

    int compared = 0, mismatched = 0, b_frames = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    // Model: a frame is a 17-entry bit array plus the index of the bit on the line.
    int          m_node [4] = '{2, 3, 2, 3};
    int          m_mode [4] = '{1, 0, 1, 2};
    int          m_fix  [4] = '{5, 0, 0, 0};
    int          m_pir  [4] = '{255, 200, 0, 255};
    logic [7:0]  m_lfsr [4];
    logic [16:0] m_frm  [4];
    int          m_pos  [4];
    logic        m_act  [4];
    logic        m_data [4];
    logic [15:0] m_cnt  [4];

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & 8'hB8)};
    endfunction

    initial begin
        int d;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 4; i++) begin
                if (reset) begin
                    m_act[i] = 1'b0; m_data[i] = 1'b0; m_cnt[i] = '0; m_pos[i] = 0; m_lfsr[i] = 8'hA5;
                end else begin
                    if (!m_act[i]) begin
                        if (send_all[i] && (m_pir[i] == 255 || int'(m_lfsr[i]) < m_pir[i])) begin
                            case (m_mode[i])
                                1: d = m_fix[i];
                                2: d = 8 - m_node[i];
                                3: d = (m_node[i] + 1) % 9;
                                default: begin
                                    d = int'(m_lfsr[i]) % 9;
                                    if (d == m_node[i]) d = (m_node[i] + 1) % 9;
                                end
                            endcase
                            if (i == 1) begin
                                b_frames++;
                                chk("mode0_dest_not_self", d == 3 || d >= 9, 0);
                            end
                            if (i == 3) chk("mode2_dest", d, 5);
                            m_frm[i] = {1'b1, 4'(d), 4'(m_node[i]), m_cnt[i][7:0]};
                            m_act[i] = 1'b1; m_pos[i] = 0; m_data[i] = 1'b1;
                        end
                    end else if (!busy_all[i]) begin
                        if (m_pos[i] == 16) begin
                            m_act[i] = 1'b0; m_data[i] = 1'b0; m_cnt[i] = m_cnt[i] + 16'd1;
                        end else begin
                            m_pos[i]++;
                            m_data[i] = m_frm[i][16-m_pos[i]];
                        end
                    end
                    m_lfsr[i] = lfsr_next(m_lfsr[i]);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("data[%0d]", i), data_v[i], m_data[i]);
                chk($sformatf("active[%0d]", i), active_v[i], m_act[i]);
                chk($sformatf("packets_sent[%0d]", i), ps_v[i], m_cnt[i]);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            for (int k = 1; k <= 3; k++) begin
                busy_r[k] = ($urandom_range(0, 3) == 0);
                send_r[k] = ($urandom_range(0, 9) != 0);
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic grab(output logic [16:0] f);
        for (int k = 16; k >= 0; k--) begin
            f[k] = data_v[0];
            step();
        end
    endtask

    initial begin
        logic [16:0] f0, f1, got;
        int cyc, seen;
        f0 = 17'b1_0101_0010_00000000;
        f1 = 17'b1_0101_0010_00000001;
        repeat (3) step();
        chk("reset_data", data_v[0], 0);
        chk("reset_active", active_v[0], 0);
        chk("reset_count", ps_v[0], 0);
        reset = 1'b0; send_a = 1'b1;
        step();
        chk("start_latency", data_v[0], 1);
        grab(got);
        chk("frame0", got, f0);
        chk("gap_data", data_v[0], 0);
        chk("count_after_frame0", ps_v[0], 1);
        step();
        grab(got);
        chk("frame1_seq1", got, f1);
        chk("count_after_frame1", ps_v[0], 2);
        // stall the 5th bit (dest LSB = 1) for three extra cycles
        step(); cyc = 1;
        repeat (4) begin step(); cyc++; end
        chk("bit5", data_v[0], 1);
        busy_a = 1'b1;
        repeat (3) begin step(); cyc++; chk("bit5_held", data_v[0], 1); end
        busy_a = 1'b0;
        for (int k = 0; k < 40 && active_v[0]; k++) begin step(); if (active_v[0]) cyc++; end
        chk("stall_frame_len", cyc, 20);
        chk("count_after_stall", ps_v[0], 3);
        // drop send at bit 6: frame still completes, no new start afterwards
        step(); cyc = 1;
        repeat (5) begin step(); cyc++; end
        send_a = 1'b0;
        for (int k = 0; k < 40 && active_v[0]; k++) begin step(); if (active_v[0]) cyc++; end
        chk("send_drop_frame_len", cyc, 17);
        chk("count_after_drop", ps_v[0], 4);
        seen = 0;
        repeat (30) begin step(); seen |= int'(active_v[0]); end
        chk("no_restart", seen, 0);
        // reset pulsed at bit 10
        send_a = 1'b1;
        step();
        repeat (9) step();
        reset = 1'b1;
        step();
        chk("midreset_data", data_v[0], 0);
        chk("midreset_active", active_v[0], 0);
        chk("midreset_count", ps_v[0], 0);
        reset = 1'b0;
        step();
        chk("post_reset_start", data_v[0], 1);
        grab(got);
        chk("post_reset_seq0", got, f0);
        repeat (20000) begin
            step();
            busy_a = ($urandom_range(0, 3) == 0);
            send_a = ($urandom_range(0, 9) != 0);
        end
        chk("pir0_count", ps_v[2], 0);
        chk("mode0_frames_ge_500", b_frames >= 500, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
